// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read, dual-write register file with per-register busy
//               scoreboard and optional write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ*$clog2(NREGS)-1:0]    raddr,
    output logic [NUM_READ*XLEN-1:0]             rdata,
    input  logic                                 we0,
    input  logic [$clog2(NREGS)-1:0]             waddr0,
    input  logic [XLEN-1:0]                      wdata0,
    input  logic                                 we1,
    input  logic [$clog2(NREGS)-1:0]             waddr1,
    input  logic [XLEN-1:0]                      wdata1,
    input  logic                                 rsv_en,
    input  logic [$clog2(NREGS)-1:0]             rsv_addr,
    output logic [NREGS-1:0]                     busy
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] w_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    // Register 0 has no storage: it is a constant zero with no producer.
    assign w_regs[0] = '0;
    assign w_busy[0] = 1'b0;

    generate
        for (genvar n = 1; n < NREGS; n++) begin : g_reg
            logic [XLEN-1:0] r_q;
            logic            r_busy;
            logic            w_hit0;
            logic            w_hit1;
            logic            w_rsv;

            assign w_hit0 = we0    && (waddr0   == AW'(n));
            assign w_hit1 = we1    && (waddr1   == AW'(n));
            assign w_rsv  = rsv_en && (rsv_addr == AW'(n));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q    <= '0;
                    r_busy <= 1'b0;
                end else begin
                    if (w_hit1) begin
                        r_q <= wdata1;
                    end else if (w_hit0) begin
                        r_q <= wdata0;
                    end
                    // A new reservation supersedes a completing producer.
                    if (w_rsv) begin
                        r_busy <= 1'b1;
                    end else if (w_hit0 || w_hit1) begin
                        r_busy <= 1'b0;
                    end
                end
            end

            assign w_regs[n] = r_q;
            assign w_busy[n] = r_busy;
        end
    endgenerate

    assign busy = w_busy;

    generate
        for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
            logic [AW-1:0]   w_ra;
            logic [XLEN-1:0] w_data;

            assign w_ra = raddr[i*AW +: AW];

            always_comb begin
                w_data = w_regs[w_ra];
                if (BYPASS != 0) begin
                    if (we1 && (waddr1 == w_ra)) begin
                        w_data = wdata1;
                    end else if (we0 && (waddr0 == w_ra)) begin
                        w_data = wdata0;
                    end
                end
                if (!rst || (w_ra == '0)) begin
                    w_data = '0;
                end
            end

            assign rdata[i*XLEN +: XLEN] = w_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's single-write, dual-read register file.
- Configurable data width, register count and read-port count.
- Two write ports with fixed priority and optional write-to-read bypass.
- A per-register busy scoreboard that the issue stage uses for hazard detection.
- Sits between decode/issue and the execute/writeback stages of the rv32i pipeline.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of architectural registers; power of two, ≥ 2. AW = $clog2(NREGS) is a derived localparam.
- NUM_READ, 2, number of combinational read ports, ≥ 1.
- BYPASS, 1, 1 = read ports return the same-cycle write data on an address match; 0 = reads see the pre-write value.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- raddr  in  NUM_READ*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NUM_READ*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1; has priority over port 0.
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- rsv_en  in  1  reserve a destination register (mark it busy).
- rsv_addr  in  AW  address to reserve.
- busy  out  NREGS  per-register busy flags; bit n is 1 while register n has an outstanding producer.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear to 0.
  - All busy bits clear to 0.
  - While rst=0, writes and reservations are ignored, bypass is disabled, and every rdata lane reads 0.
- Register 0 is hardwired zero:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
  - busy[0] is always 0; reservations of address 0 are dropped.
- Writes are sampled on the rising clk edge:
  - regs[waddrN] <= wdataN when weN=1.
  - If both ports write the same nonzero address in one cycle, port 1's data is stored and port 0's is discarded.
- Reads are combinational with zero latency:
  - rdata lane i = regs[raddr lane i].
  - With BYPASS=1, a lane whose nonzero address matches an enabled write this cycle returns that write's data. Port 1 wins if both ports match.
  - With BYPASS=0, the lane shows the stored value until the edge and the new value after it.
- Scoreboard update on the rising clk edge, for each nonzero n:
  - Set: busy[n] <= 1 if rsv_en=1 and rsv_addr=n.
  - Clear: busy[n] <= 0 if (we0 & waddr0=n) or (we1 & waddr1=n).
  - Set and clear on the same n in the same cycle: set wins (a new producer supersedes the completing one).
  - Writes to a non-busy register are legal and leave busy at 0.
  - Reserving an already-busy register keeps it at 1.
- No internal stall or backpressure; all inputs are accepted every cycle.
- Width rules:
  - Addresses are unsigned AW bits.
  - rdata lanes are exactly XLEN bits; no sign extension or truncation inside the block.
- Reset mid-operation: asserting rst in any cycle immediately zeroes all state and outputs. The first write after deassertion takes effect on the first rising edge with rst=1.

Test Plan:
- Reset:
  - Stimulus: hold rst=0, drive we0=1, waddr0=5, wdata0=0xFF, rsv_en=1, rsv_addr=5; then release rst.
  - Required: during reset, all rdata=0 and busy=0. After release, raddr lane0=5 reads 0 (writes during reset were ignored).
- Basic write/read:
  - Stimulus: we0=1, waddr0=2, wdata0=255; next cycle we0=0, raddr lane0=2. Then we1=1, waddr1=4, wdata1=511; next cycle raddr lane1=4.
  - Required: lane0=255, lane1=511, lane0 still 255.
- Zero register and priority:
  - Stimulus: we0=1, waddr0=0, wdata0=0xDEAD, then read address 0. Then in one cycle we0=1/we1=1, both waddr=7, wdata0=0x11, wdata1=0x22; read 7 next cycle.
  - Required: address 0 reads 0; address 7 reads 0x22.
- Bypass:
  - Stimulus: BYPASS=1, regs[3]=0x10; in one cycle drive we0=1, waddr0=3, wdata0=0x20 with raddr lane0=3.
  - Required: lane0=0x20 in the same cycle.
  - Rerun with BYPASS=0: lane0=0x10 before the edge, 0x20 after it.
- Scoreboard:
  - Stimulus: rsv_en=1, rsv_addr=9; next cycle we1=1, waddr1=9 together with rsv_en=1, rsv_addr=9; next cycle we0=1, waddr0=9 with rsv_en=0.
  - Required: busy[9]=1 after the first edge, stays 1 after the second (set wins), returns to 0 after the third.
  - Also: rsv_addr=0 leaves busy=0.
- Async reset mid-run:
  - Stimulus: with busy[9]=1 and regs[2]=255, pulse rst=0 for half a clock period between edges.
  - Required: busy and rdata go to 0 immediately, without waiting for a clock edge.
